// File: rtl/psd_sqrt_if.sv
// Control/data bundle between a controller (master) and the psd_sqrt datapath (slave).
interface psd_sqrt_if;
   logic        start;
   logic        stop;
   logic [31:0] xin;
   logic [15:0] sqrt;

   modport master (
      output start,
      output stop,
      output xin,
      input  sqrt
   );

   modport slave (
      input  start,
      input  stop,
      input  xin,
      output sqrt
   );
endinterface

// File: rtl/psd_sqrt.sv
// Sequential 32-bit integer square root, one result bit per clock, MSB first.
// Define PSDSQRT_ROUND_EN to round the loaded result to nearest (saturating at 0xFFFF).
module psd_sqrt (
   input  logic          clock,
   input  logic          reset,
   psd_sqrt_if.slave     bus
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t      r_state;
   state_t      w_stateNext;
   logic        w_iterate;

   logic [31:0] r_xreg;
   logic [15:0] r_root;
   logic [15:0] r_mask;
   logic [4:0]  r_cnt;
   logic [15:0] r_sqrt;

   logic [15:0] w_trial;
   logic [31:0] w_trialSq;
   logic        w_fits;
   logic [15:0] w_stopValue;

   assign w_trial   = r_root | r_mask;
   assign w_trialSq = {16'd0, w_trial} * {16'd0, w_trial};
   assign w_fits    = (r_xreg >= w_trialSq);

`ifdef PSDSQRT_ROUND_EN
   logic [31:0] w_rootSq;
   logic [31:0] w_remainder;
   logic        w_roundUp;

   // Remainder is never negative: every accepted trial kept root^2 <= xreg.
   assign w_rootSq    = {16'd0, r_root} * {16'd0, r_root};
   assign w_remainder = r_xreg - w_rootSq;
   assign w_roundUp   = (w_remainder > {16'd0, r_root});
   assign w_stopValue = (w_roundUp && (r_root != 16'hFFFF)) ? (r_root + 16'd1) : r_root;
`else
   assign w_stopValue = r_root;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // A start always wins, so it aborts and restarts any run in progress.
   always_comb begin
      w_stateNext = r_state;
      w_iterate   = 1'b0;
      if (bus.start) begin
         w_stateNext = BUSY;
      end else if (r_state == BUSY) begin
         w_iterate = 1'b1;
         if (r_cnt == 5'd15) begin
            w_stateNext = IDLE;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_xreg <= 32'd0;
         r_root <= 16'd0;
         r_mask <= 16'd0;
         r_cnt  <= 5'd0;
      end else if (bus.start) begin
         r_xreg <= bus.xin;
         r_root <= 16'd0;
         r_mask <= 16'h8000;
         r_cnt  <= 5'd0;
      end else if (w_iterate) begin
         if (w_fits) begin
            r_root <= w_trial;
         end
         r_mask <= r_mask >> 1;
         r_cnt  <= r_cnt + 5'd1;
      end
   end

   // Stop samples the root as it stood before this edge, even when start coincides.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_sqrt <= 16'd0;
      end else if (bus.stop) begin
         r_sqrt <= w_stopValue;
      end
   end

   assign bus.sqrt = r_sqrt;

endmodule

// File: tb/tb_psd_sqrt.sv
// Self-checking bench for psd_sqrt against an arithmetic square-root model.
module tb_psd_sqrt;

   logic clock;
   logic reset;
   int   checkCount;
   int   errorCount;

   psd_sqrt_if sqrtBus ();

   psd_sqrt dut (
      .clock (clock),
      .reset (reset),
      .bus   (sqrtBus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference: largest r with r*r <= x by binary search, then optional round-to-nearest.
   function automatic logic [15:0] expectedRoot(input logic [31:0] x);
      longint lo;
      longint hi;
      longint mid;
      longint xv;
      xv = longint'(x);
      lo = 0;
      hi = 65535;
      while (lo < hi) begin
         mid = (lo + hi + 1) / 2;
         if (mid * mid <= xv) lo = mid;
         else hi = mid - 1;
      end
`ifdef PSDSQRT_ROUND_EN
      if ((xv - lo * lo) > lo && lo < 65535) lo = lo + 1;
`endif
      return 16'(lo);
   endfunction

   // Full protocol: start at E0, stop sampled at E17, result read after E17.
   task automatic runOp(input logic [31:0] x, output logic [15:0] result);
      @(negedge clock);
      sqrtBus.start = 1'b1;
      sqrtBus.xin   = x;
      @(negedge clock);
      sqrtBus.start = 1'b0;
      sqrtBus.xin   = $urandom;
      repeat (16) @(negedge clock);
      sqrtBus.stop = 1'b1;
      @(negedge clock);
      sqrtBus.stop = 1'b0;
      result = sqrtBus.sqrt;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #3;
      checkCount++;
      if (sqrtBus.sqrt !== 16'd0) begin
         errorCount++;
         $display("[TB] FAIL reset_hold: sqrt=%0d expected 0", sqrtBus.sqrt);
      end
      #20;
      reset = 1'b1;
      @(negedge clock);
      checkCount++;
      if (sqrtBus.sqrt !== 16'd0) begin
         errorCount++;
         $display("[TB] FAIL reset_release: sqrt=%0d expected 0", sqrtBus.sqrt);
      end
   endtask

   task automatic test_stop_no_start();
      @(negedge clock);
      sqrtBus.stop = 1'b1;
      @(negedge clock);
      sqrtBus.stop = 1'b0;
      checkCount++;
      if (sqrtBus.sqrt !== 16'd0) begin
         errorCount++;
         $display("[TB] FAIL stop_no_start: sqrt=%0d expected 0", sqrtBus.sqrt);
      end
   endtask

   task automatic test_known_values();
      logic [31:0] xs [6];
      logic [15:0] got;
      logic [15:0] exp;
      xs = '{32'd123456, 32'd4995, 32'd0, 32'd1, 32'hFFFFFFFF, 32'hFFFE0001};
      for (int i = 0; i < 6; i++) begin
         runOp(xs[i], got);
         exp = expectedRoot(xs[i]);
         checkCount++;
         if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL known x=%0d: sqrt=%0d expected %0d", xs[i], got, exp);
         end
      end
      // Fixed constants guard the model itself on the documented points.
      runOp(32'd123456, got);
      checkCount++;
      if (got !== 16'd351) begin
         errorCount++;
         $display("[TB] FAIL const_123456: sqrt=%0d expected 351", got);
      end
      runOp(32'd4995, got);
      checkCount++;
`ifdef PSDSQRT_ROUND_EN
      if (got !== 16'd71) begin
         errorCount++;
         $display("[TB] FAIL const_4995: sqrt=%0d expected 71", got);
      end
`else
      if (got !== 16'd70) begin
         errorCount++;
         $display("[TB] FAIL const_4995: sqrt=%0d expected 70", got);
      end
`endif
      runOp(32'hFFFFFFFF, got);
      checkCount++;
      if (got !== 16'hFFFF) begin
         errorCount++;
         $display("[TB] FAIL const_max: sqrt=%0d expected 65535", got);
      end
   endtask

   task automatic test_sweep();
      logic [15:0] got;
      logic [15:0] exp;
      for (int x = 0; x <= 4995; x += 5) begin
         runOp(32'(x), got);
         exp = expectedRoot(32'(x));
         checkCount++;
         if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL sweep x=%0d: sqrt=%0d expected %0d", x, got, exp);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] x;
      logic [15:0] got;
      logic [15:0] exp;
      for (int i = 0; i < 60; i++) begin
         x = $urandom;
         if (i % 4 == 1) x = x >> (i % 31);
         runOp(x, got);
         exp = expectedRoot(x);
         checkCount++;
         if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL random x=%0d: sqrt=%0d expected %0d", x, got, exp);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] got;
      runOp(32'd65536, got);
      @(negedge clock);
      sqrtBus.start = 1'b1;
      sqrtBus.xin   = 32'd123456;
      @(negedge clock);
      sqrtBus.start = 1'b0;
      repeat (8) @(negedge clock);
      #1;
      reset = 1'b0;
      #1;
      checkCount++;
      if (sqrtBus.sqrt !== 16'd0) begin
         errorCount++;
         $display("[TB] FAIL reset_mid: sqrt=%0d expected 0", sqrtBus.sqrt);
      end
      #12;
      reset = 1'b1;
      test_stop_no_start();
      runOp(32'd123456, got);
      checkCount++;
      if (got !== expectedRoot(32'd123456)) begin
         errorCount++;
         $display("[TB] FAIL reset_mid_rerun: sqrt=%0d expected %0d", got, expectedRoot(32'd123456));
      end
   endtask

   task automatic test_restart();
      @(negedge clock);
      sqrtBus.start = 1'b1;
      sqrtBus.xin   = 32'd123456;
      @(negedge clock);
      sqrtBus.start = 1'b0;
      repeat (4) @(negedge clock);
      sqrtBus.start = 1'b1;
      sqrtBus.xin   = 32'd100;
      @(negedge clock);
      sqrtBus.start = 1'b0;
      sqrtBus.xin   = 32'd999999;
      repeat (16) @(negedge clock);
      sqrtBus.stop = 1'b1;
      @(negedge clock);
      sqrtBus.stop = 1'b0;
      checkCount++;
      if (sqrtBus.sqrt !== 16'd10) begin
         errorCount++;
         $display("[TB] FAIL restart: sqrt=%0d expected 10", sqrtBus.sqrt);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] xq [$];
      logic [15:0] exp;
      for (int i = 0; i < 8; i++) xq.push_back($urandom);
      @(negedge clock);
      sqrtBus.start = 1'b1;
      sqrtBus.xin   = xq[0];
      @(negedge clock);
      sqrtBus.start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         repeat (16) @(negedge clock);
         sqrtBus.stop = 1'b1;
         if (i < 7) begin
            sqrtBus.start = 1'b1;
            sqrtBus.xin   = xq[i + 1];
         end
         @(negedge clock);
         sqrtBus.stop  = 1'b0;
         sqrtBus.start = 1'b0;
         exp = expectedRoot(xq[i]);
         checkCount++;
         if (sqrtBus.sqrt !== exp) begin
            errorCount++;
            $display("[TB] FAIL back_to_back x=%0d: sqrt=%0d expected %0d", xq[i], sqrtBus.sqrt, exp);
         end
      end
   endtask

   initial begin
      checkCount    = 0;
      errorCount    = 0;
      sqrtBus.start = 1'b0;
      sqrtBus.stop  = 1'b0;
      sqrtBus.xin   = 32'd0;
      test_reset();
      test_stop_no_start();
      test_known_values();
      test_sweep();
      test_random();
      test_reset_mid();
      test_restart();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
